// File: rtl/pc_ctrl_pkg.sv
// Shared definitions for the program-counter run controller: opcodes,
// FSM state encoding, CFG bit positions and the command-acceptance rule.
package pc_ctrl_pkg;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_RUN  = 2'b01;
    localparam logic [1:0] OP_STOP = 2'b10;
    localparam logic [1:0] OP_CFG  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_RUN  = 2'b10,
        ST_DONE = 2'b11
    } pc_state_e;

    localparam int CFG_OE_BIT       = 0;
    localparam int CFG_FREE_RUN_BIT = 1;

    // IDLE takes every opcode; RUN only takes STOP while more than one
    // step is still outstanding, so the final step always completes.
    function automatic logic cmd_accepts(input pc_state_e st,
                                         input logic [1:0] op,
                                         input logic       last);
        logic ok;
        case (st)
            ST_IDLE: ok = 1'b1;
            ST_RUN:  ok = (op == OP_STOP) && !last;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/pc_step_cnt.sv
// Loadable 8-bit down-counter holding the number of RUN steps still owed.
// It never wraps: a decrement request at 1 (or 0) leaves the value alone.
module pc_step_cnt
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       dec,
    output logic       last
);

    logic [7:0] count_r;

    // Remaining-step register: load has priority over decrement
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= 8'd0;
        end else if (load) begin
            count_r <= load_val;
        end else if (dec && (count_r > 8'd1)) begin
            count_r <= count_r - 8'd1;
        end else begin
            count_r <= count_r;
        end
    end

    assign last = (count_r == 8'd1);

endmodule

// File: rtl/pc_run_ctrl.sv
// Command-driven controller for an 8-bit program counter: loads a value,
// runs it for N steps (abortable by STOP), and configures output drive
// and free-run. All outputs are decoded from registered state and flags.
module pc_run_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter logic DEFAULT_DRIVE = 1'b1,
    parameter logic DEFAULT_EN    = 1'b0
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_arg,
    output logic       pc_load,
    output logic [7:0] pc_load_val,
    output logic       pc_en,
    output logic       pc_oe,
    output logic       busy,
    output logic       done,
    output logic       aborted
);

    pc_state_e  state_r;
    logic       free_run_r;
    logic       pc_oe_r;
    logic [7:0] pc_load_val_r;
    logic       aborted_r;

    logic       cmd_ready_s;
    logic       accept_s;
    logic       cnt_load_s;
    logic       cnt_dec_s;
    logic       cnt_last_s;

    // Handshake: nothing is accepted while reset is held
    always_comb begin
        cmd_ready_s = 1'b0;
        if (rst) begin
            cmd_ready_s = 1'b0;
        end else begin
            cmd_ready_s = cmd_accepts(state_r, cmd_op, cnt_last_s);
        end
    end

    assign accept_s   = cmd_valid && cmd_ready_s;
    // A zero-length RUN never enters RUN, so the counter need not be loaded
    assign cnt_load_s = (state_r == ST_IDLE) && accept_s && (cmd_op == OP_RUN)
                        && (cmd_arg != 8'd0);
    assign cnt_dec_s  = (state_r == ST_RUN) && !cnt_last_s;

    pc_step_cnt u_step_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load_s),
        .load_val (cmd_arg),
        .dec      (cnt_dec_s),
        .last     (cnt_last_s)
    );

    // Control FSM with its flag registers (load value, abort cause, config)
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            pc_load_val_r <= 8'h00;
            aborted_r     <= 1'b0;
            pc_oe_r       <= DEFAULT_DRIVE;
            free_run_r    <= DEFAULT_EN;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        case (cmd_op)
                            OP_LOAD: begin
                                pc_load_val_r <= cmd_arg;
                                state_r       <= ST_LOAD;
                            end
                            OP_RUN: begin
                                if (cmd_arg == 8'd0) begin
                                    aborted_r <= 1'b0;
                                    state_r   <= ST_DONE;
                                end else begin
                                    state_r   <= ST_RUN;
                                end
                            end
                            OP_CFG: begin
                                pc_oe_r    <= cmd_arg[CFG_OE_BIT];
                                free_run_r <= cmd_arg[CFG_FREE_RUN_BIT];
                            end
                            default: begin
                                // STOP while idle is a no-op
                                state_r <= ST_IDLE;
                            end
                        endcase
                    end
                end
                ST_LOAD: begin
                    state_r <= ST_IDLE;
                end
                ST_RUN: begin
                    if (accept_s) begin
                        aborted_r <= 1'b1;
                        state_r   <= ST_DONE;
                    end else if (cnt_last_s) begin
                        aborted_r <= 1'b0;
                        state_r   <= ST_DONE;
                    end else begin
                        state_r   <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready   = cmd_ready_s;
    assign pc_load     = (state_r == ST_LOAD);
    assign pc_load_val = pc_load_val_r;
    assign pc_en       = (state_r == ST_RUN) || ((state_r == ST_IDLE) && free_run_r);
    assign pc_oe       = pc_oe_r;
    assign busy        = (state_r != ST_IDLE);
    assign done        = (state_r == ST_DONE);
    assign aborted     = aborted_r;

endmodule

// File: tb/tb_pc_run_ctrl.sv
// Scoreboard bench for pc_run_ctrl: each stimulus cycle pushes the
// hand-computed output vector for that cycle; a monitor on the falling
// edge pops and compares field by field.
module tb_pc_run_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_arg;
    logic       pc_load;
    logic [7:0] pc_load_val;
    logic       pc_en;
    logic       pc_oe;
    logic       busy;
    logic       done;
    logic       aborted;

    localparam logic [1:0] L = 2'b00;
    localparam logic [1:0] R = 2'b01;
    localparam logic [1:0] S = 2'b10;
    localparam logic [1:0] C = 2'b11;

    typedef struct {
        string      tag;
        logic       rdy;
        logic       ld;
        logic [7:0] lv;
        logic       en;
        logic       oe;
        logic       bsy;
        logic       dn;
        logic       ab;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    pc_run_ctrl #(.DEFAULT_DRIVE(1'b1), .DEFAULT_EN(1'b0)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_arg     (cmd_arg),
        .pc_load     (pc_load),
        .pc_load_val (pc_load_val),
        .pc_en       (pc_en),
        .pc_oe       (pc_oe),
        .busy        (busy),
        .done        (done),
        .aborted     (aborted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input string fld, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s.%s actual=%0h required=%0h", tag, fld, act, req);
        end
    endtask

    // Monitor: compare the outputs presented this cycle with the oldest expectation
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk(e.tag, "cmd_ready",   int'(cmd_ready),   int'(e.rdy));
            chk(e.tag, "pc_load",     int'(pc_load),     int'(e.ld));
            chk(e.tag, "pc_load_val", int'(pc_load_val), int'(e.lv));
            chk(e.tag, "pc_en",       int'(pc_en),       int'(e.en));
            chk(e.tag, "pc_oe",       int'(pc_oe),       int'(e.oe));
            chk(e.tag, "busy",        int'(busy),        int'(e.bsy));
            chk(e.tag, "done",        int'(done),        int'(e.dn));
            chk(e.tag, "aborted",     int'(aborted),     int'(e.ab));
        end
    end

    // Drive one cycle of inputs and queue the outputs expected during it
    task automatic step(input string tag, input logic v, input logic [1:0] op,
                        input logic [7:0] arg, input logic rdy, input logic ld,
                        input logic [7:0] lv, input logic en, input logic oe,
                        input logic bsy, input logic dn, input logic ab);
        exp_t e;
        cmd_valid = v;
        cmd_op    = op;
        cmd_arg   = arg;
        e.tag = tag; e.rdy = rdy; e.ld = ld; e.lv = lv; e.en = en;
        e.oe = oe; e.bsy = bsy; e.dn = dn; e.ab = ab;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = L; cmd_arg = 8'h00;
        @(posedge clk);
        #1;
        //   tag      v  op arg    rdy ld lv     en oe bsy dn ab
        step("reset",  1'b0, L, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        // LOAD 0x5A
        step("ld_acc", 1'b1, L, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("ld_st",  1'b0, L, 8'h00, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step("ld_end", 1'b0, L, 8'h00, 1'b1, 1'b0, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        // RUN 3
        step("r3_acc", 1'b1, R, 8'd3,  1'b1, 1'b0, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            step("r3_run", 1'b0, L, 8'h00, 1'b0, 1'b0, 8'h5A, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step("r3_done",1'b0, L, 8'h00, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        step("r3_idle",1'b0, L, 8'h00, 1'b1, 1'b0, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        // RUN 10, STOP in the 4th RUN cycle
        step("r10_acc",1'b1, R, 8'd10, 1'b1, 1'b0, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            step("r10_run",1'b0, L, 8'h00, 1'b0, 1'b0, 8'h5A, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step("r10_stp",1'b1, S, 8'h00, 1'b1, 1'b0, 8'h5A, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step("r10_dn", 1'b0, L, 8'h00, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        step("r10_idl",1'b0, L, 8'h00, 1'b1, 1'b0, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        // RUN 0
        step("r0_acc", 1'b1, R, 8'd0,  1'b1, 1'b0, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        step("r0_done",1'b0, L, 8'h00, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        step("r0_idle",1'b0, L, 8'h00, 1'b1, 1'b0, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        // RUN 2, STOP offered in the final cycle is refused
        step("r2_acc", 1'b1, R, 8'd2,  1'b1, 1'b0, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("r2_run1",1'b0, L, 8'h00, 1'b0, 1'b0, 8'h5A, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step("r2_stp", 1'b1, S, 8'h00, 1'b0, 1'b0, 8'h5A, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step("r2_done",1'b0, L, 8'h00, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        step("r2_idle",1'b0, L, 8'h00, 1'b1, 1'b0, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        // STOP while idle is a no-op
        step("istp",   1'b1, S, 8'h00, 1'b1, 1'b0, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("istp_nx",1'b0, L, 8'h00, 1'b1, 1'b0, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        // CFG 0x02: free-run, drive off
        step("cfg02",  1'b1, C, 8'h02, 1'b1, 1'b0, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            step("free",   1'b0, L, 8'h00, 1'b1, 1'b0, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        // CFG 0x01: stop free-run, drive on
        step("cfg01",  1'b1, C, 8'h01, 1'b1, 1'b0, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step("cfg01_n",1'b0, L, 8'h00, 1'b1, 1'b0, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        // CFG 0xFC: upper bits ignored, both config bits cleared
        step("cfgfc",  1'b1, C, 8'hFC, 1'b1, 1'b0, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("cfgfc_n",1'b0, L, 8'h00, 1'b1, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        // RUN 8 with reset in its 2nd RUN cycle
        step("r8_acc", 1'b1, R, 8'd8,  1'b1, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("r8_run1",1'b0, L, 8'h00, 1'b0, 1'b0, 8'h5A, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        step("r8_rst", 1'b0, L, 8'h00, 1'b0, 1'b0, 8'h5A, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++)
            step("post_rst",1'b0, L, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        chk("end", "queue_left", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_run_ctrl.md
PC_RUN_CTRL -- requirements
Module: pc_run_ctrl

Interface
REQ-001 SHALL have parameter DEFAULT_DRIVE, default 1'b1, reset value of pc_oe.
REQ-002 SHALL have parameter DEFAULT_EN, default 1'b0, reset value of the free-run flag.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  in  1  reset; synchronous, active-high.
REQ-005 SHALL have port cmd_valid  in  1  command offered.
REQ-006 SHALL have port cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at a rising edge.
REQ-007 SHALL have port cmd_op  in  2  opcode: 00 LOAD, 01 RUN, 10 STOP, 11 CFG.
REQ-008 SHALL have port cmd_arg  in  8  operand: load value, step count or config bits.
REQ-009 SHALL have port pc_load  out  1  one-cycle load strobe to the counter.
REQ-010 SHALL have port pc_load_val  out  8  value to load; registered.
REQ-011 SHALL have port pc_en  out  1  counter count-enable.
REQ-012 SHALL have port pc_oe  out  1  counter output-drive enable.
REQ-013 SHALL have port busy  out  1  high whenever state != IDLE.
REQ-014 SHALL have port done  out  1  one-cycle pulse at end of a RUN.
REQ-015 SHALL have port aborted  out  1  qualifies done; 1 = RUN ended by STOP.

Function
REQ-016 SHALL implement FSM states IDLE, LOAD, RUN and DONE; all outputs Moore, decoded from registered state and flags.
REQ-017 SHALL drive cmd_ready=1 in IDLE for every op; in LOAD and DONE, 0; in RUN, 1 only when cmd_op==STOP and remaining>1.
REQ-018 SHALL, on LOAD accepted at edge k, capture cmd_arg into pc_load_val, assert pc_load for exactly cycle k+1 (state LOAD), then return to IDLE at k+2.
REQ-019 SHALL hold pc_load_val until the next accepted LOAD.
REQ-020 SHALL, on RUN with N>0 accepted at edge k, enter RUN with remaining=N and hold pc_en=1 for exactly N cycles (k+1..k+N).
REQ-021 SHALL decrement remaining once per RUN cycle, enter DONE when remaining==1, and give exactly N counter steps.
REQ-022 SHALL, in DONE, drive done=1 and pc_en=0 for one cycle, then return to IDLE.
REQ-023 SHALL, on RUN with N==0, go directly to DONE at k+1 with aborted=0 and no pc_en cycle.
REQ-024 SHALL, on STOP accepted in RUN cycle j, enter DONE at j+1 with pc_en=0 and aborted=1; the counter has then advanced (N - remaining_at_j + 1) steps.
REQ-025 SHALL accept STOP in IDLE as a no-op: no done, state unchanged.
REQ-026 SHALL never accept STOP in the final RUN cycle; completion is then normal with aborted=0.
REQ-027 SHALL, on CFG accepted, update pc_oe=cmd_arg[0] and free_run=cmd_arg[1] at the next cycle, ignore cmd_arg[7:2], and remain in IDLE.
REQ-028 SHALL compute pc_en = (state==RUN) | (state==IDLE & free_run); pc_en SHALL be 0 in LOAD and DONE.
REQ-029 SHALL hold aborted stable from DONE until the next DONE.
REQ-030 SHALL keep the remaining counter 8 bits wide with no wrap; it is never decremented below 1.

Reset
REQ-031 SHALL, when rst=1 at an edge, regardless of state: state=IDLE, remaining=0, pc_load=0, pc_load_val=0x00, done=0, aborted=0, pc_oe=DEFAULT_DRIVE, free_run=DEFAULT_EN.
REQ-032 SHALL drive cmd_ready=0 while rst is high and resume accepting commands the first cycle after rst deasserts.
REQ-033 SHALL, on reset mid-RUN, drop pc_en (if DEFAULT_EN=0) at the next edge with no done pulse.

Structure
REQ-034 SHALL take opcode constants (OP_LOAD, OP_RUN, OP_STOP, OP_CFG), the FSM state encoding and CFG bit positions from shared package pc_ctrl_pkg.
REQ-035 SHALL place the loadable 8-bit down-counter for remaining in sub-module pc_step_cnt, with ports load, load_val, dec, last.
REQ-036 SHALL be instantiable beside tt_um_8_prog_counter with pc_load, pc_load_val, pc_en and pc_oe wired directly to it.

Verification
REQ-037 SHALL cover: reset, then LOAD 0x5A -> pc_load high exactly one cycle with pc_load_val=0x5A; busy high one cycle; cmd_ready low that cycle.
REQ-038 SHALL cover: RUN 3 -> pc_en high exactly 3 consecutive cycles, then done=1 with aborted=0 one cycle, cmd_ready=1 next cycle.
REQ-039 SHALL cover: RUN 10, STOP offered in 4th RUN cycle -> pc_en high 4 cycles, done=1 with aborted=1, 4 counter steps.
REQ-040 SHALL cover: RUN 0 -> no pc_en cycle; done=1 with aborted=0 one cycle after acceptance; also RUN 2 with STOP offered in cycle 2 -> STOP not accepted, aborted=0.
REQ-041 SHALL cover: CFG 0x02 then idle -> pc_en continuously high in IDLE, pc_oe=0; CFG 0x01 -> pc_en=0, pc_oe=1.
REQ-042 SHALL cover: rst asserted in 2nd cycle of RUN 8 -> next cycle state IDLE, pc_en=0, done never pulses, pc_oe=1.
